inport_input_conditioner: RTL

//   Front end for the 32-bit Inport. Synchronises raw board switches and a
//   "load" push-button into clk, then debounces the button with a 4-state FSM.
//   On each qualified press it emits a one-cycle strobe with a stable data

---
 rtl/inport_input_conditioner_pkg.sv | 23 ++
 rtl/inport_input_conditioner_sync_chain.sv | 28 ++
 rtl/inport_input_conditioner.sv | 108 ++++++++++
 3 files changed

// File: rtl/inport_input_conditioner_pkg.sv
// Shared types and defaults for the Inport input conditioner.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package inport_input_conditioner_pkg;

    // Debounce FSM encodings; all four 2-bit codes are used.
    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        HELD_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } btn_state_t;

    localparam int SYNC_STAGES_DEFAULT     = 2;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 16;

    // Debounced level implied by a state: the button counts as pressed
    // from the moment it qualifies until the release has qualified.
    function automatic logic is_high_state(input btn_state_t s);
        return (s == HELD_HIGH) || (s == WAIT_LOW);
    endfunction

endpackage

// File: rtl/inport_input_conditioner_sync_chain.sv
// W-bit multi-flop synchroniser for asynchronous board inputs.
// Latency: STAGES clk edges from input to q.
// Backpressure: none; samples every cycle.
module sync_chain #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // stage[0] is the metastability-catching flop, stage[STAGES-1] the output
    logic [STAGES-1:0][W-1:0] stage;

    // Shift the raw input through the chain; clear synchronously
    always_ff @(posedge clk) begin
        if (clr) begin
            stage <= '0;
        end else begin
            stage <= {stage[STAGES-2:0], d};
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/inport_input_conditioner.sv
// Synchronises switches + load button, debounces the button, strobes the switch word.
// Latency: strobe in the cycle after edge E0+SYNC_STAGES+DEBOUNCE_CYCLES (E0 = first high sample).
// Backpressure: none; the Inport must accept every one-cycle strobe.
module inport_input_conditioner
    import inport_input_conditioner_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] sw_in,
    input  logic             btn_in,
    output logic [WIDTH-1:0] data_out,
    output logic             strobe,
    output logic             btn_level
);

    localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sw_s;
    logic             btn_s;
    btn_state_t       state;
    logic [CNT_W-1:0] cnt;

    sync_chain #(
        .W      (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sw_sync (
        .clk (clk),
        .clr (clr),
        .d   (sw_in),
        .q   (sw_s)
    );

    sync_chain #(
        .W      (1),
        .STAGES (SYNC_STAGES)
    ) u_btn_sync (
        .clk (clk),
        .clr (clr),
        .d   (btn_in),
        .q   (btn_s)
    );

    // Debounce FSM with stable-cycle counter and registered strobe/data/level;
    // the counter restarts on every state change and never runs past CNT_MAX.
    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= IDLE_LOW;
            cnt       <= '0;
            data_out  <= '0;
            strobe    <= 1'b0;
            btn_level <= 1'b0;
        end else begin
            strobe    <= 1'b0;
            btn_level <= is_high_state(state);
            case (state)
                IDLE_LOW: begin
                    if (btn_s) begin
                        state <= WAIT_HIGH;
                        cnt   <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!btn_s) begin
                        state <= IDLE_LOW;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state     <= HELD_HIGH;
                        cnt       <= '0;
                        strobe    <= 1'b1;
                        data_out  <= sw_s;
                        btn_level <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HELD_HIGH: begin
                    if (!btn_s) begin
                        state <= WAIT_LOW;
                        cnt   <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (btn_s) begin
                        state <= HELD_HIGH;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state     <= IDLE_LOW;
                        cnt       <= '0;
                        btn_level <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE_LOW;
                    cnt       <= '0;
                    btn_level <= 1'b0;
                end
            endcase
        end
    end

endmodule
